// File: rtl/dds_playback_sequencer.sv
// rtl/dds_playback_sequencer.sv - DDS instruction playback address sequencer for one BRAM channel
//
// Purpose: on an accepted start, wait cfg_delay cycles, then step the BRAM read
// address through [start_addr, start_addr+num_instr) holding each instruction for
// cfg_dwell cycles, repeating for cfg_loops passes (0 = until abort).
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_start, i_abort         1-cycle commands
//   i_cfg_*                  playback configuration, captured on accepted start
//   o_mem_addr, o_mem_en     BRAM address / read enable
//   o_instr_valid            o_mem_en delayed by RD_LATENCY
//   o_busy                   high in DELAY and RUN
//   o_done, o_aborted        completion / abort pulses
//   o_cfg_err                start rejected for illegal configuration
module dds_playback_sequencer #(
    parameter int ADDR_W     = 17,
    parameter int DWELL_W    = 16,
    parameter int DELAY_W    = 32,
    parameter int LOOP_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_cfg_start_addr,
    input  logic [ADDR_W:0]   i_cfg_num_instr,
    input  logic [DWELL_W-1:0] i_cfg_dwell,
    input  logic [DELAY_W-1:0] i_cfg_delay,
    input  logic [LOOP_W-1:0] i_cfg_loops,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_en,
    output logic              o_instr_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic              o_cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;

    // Shadow configuration, frozen for the whole playback
    logic [ADDR_W-1:0]   r_start_addr;
    logic [ADDR_W:0]     r_num_instr;
    logic [DWELL_W-1:0]  r_dwell;
    logic [DELAY_W-1:0]  r_delay;
    logic [LOOP_W-1:0]   r_loops;

    logic [ADDR_W:0]     r_idx;
    logic [DWELL_W-1:0]  r_dwell_cnt;
    logic [DELAY_W-1:0]  r_delay_cnt;
    logic [LOOP_W-1:0]   r_pass_cnt;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_en;
    logic                r_done;
    logic                r_aborted;
    logic                r_cfg_err;
    logic [RD_LATENCY-1:0] r_valid_pipe;

    logic                w_cfg_bad;
    logic                w_last_dwell;
    logic                w_last_instr;
    logic                w_last_delay;
    logic                w_more_passes;
    logic [ADDR_W:0]     w_next_idx;
    logic [ADDR_W-1:0]   w_next_addr;

    assign w_cfg_bad    = (i_cfg_num_instr == '0) || (i_cfg_dwell == '0);
    assign w_last_dwell = (r_dwell_cnt == r_dwell - DWELL_W'(1));
    assign w_last_instr = (r_idx == r_num_instr - (ADDR_W+1)'(1));
    assign w_last_delay = (r_delay_cnt == r_delay - DELAY_W'(1));
    // One extra bit so passes_done+1 cannot wrap when loops is all ones
    assign w_more_passes = (r_loops == '0) ||
                           (({1'b0, r_pass_cnt} + (LOOP_W+1)'(1)) < {1'b0, r_loops});
    assign w_next_idx   = r_idx + (ADDR_W+1)'(1);
    // Address wraps modulo 2^ADDR_W by truncation
    assign w_next_addr  = r_start_addr + w_next_idx[ADDR_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_start_addr <= '0;
            r_num_instr  <= '0;
            r_dwell      <= '0;
            r_delay      <= '0;
            r_loops      <= '0;
            r_idx        <= '0;
            r_dwell_cnt  <= '0;
            r_delay_cnt  <= '0;
            r_pass_cnt   <= '0;
            r_mem_addr   <= '0;
            r_mem_en     <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_mem_en  <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A simultaneous abort blocks the start
                    if (i_start && !i_abort) begin
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_start_addr <= i_cfg_start_addr;
                            r_num_instr  <= i_cfg_num_instr;
                            r_dwell      <= i_cfg_dwell;
                            r_delay      <= i_cfg_delay;
                            r_loops      <= i_cfg_loops;
                            r_idx        <= '0;
                            r_dwell_cnt  <= '0;
                            r_delay_cnt  <= '0;
                            r_pass_cnt   <= '0;
                            if (i_cfg_delay != '0) begin
                                r_state <= S_DELAY;
                            end else begin
                                r_state    <= S_RUN;
                                r_mem_en   <= 1'b1;
                                r_mem_addr <= i_cfg_start_addr;
                            end
                        end
                    end
                end
                S_DELAY: begin
                    if (i_abort) begin
                        r_state   <= S_IDLE;
                        r_aborted <= 1'b1;
                    end else if (w_last_delay) begin
                        r_state    <= S_RUN;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= r_start_addr;
                    end else begin
                        r_delay_cnt <= r_delay_cnt + DELAY_W'(1);
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        r_state   <= S_IDLE;
                        r_aborted <= 1'b1;
                    end else if (!w_last_dwell) begin
                        r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
                    end else begin
                        r_dwell_cnt <= '0;
                        if (!w_last_instr) begin
                            r_idx      <= w_next_idx;
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= w_next_addr;
                        end else if (w_more_passes) begin
                            // Next pass starts immediately, no gap cycle
                            r_idx      <= '0;
                            r_pass_cnt <= r_pass_cnt + LOOP_W'(1);
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= r_start_addr;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // done already issued; abort here has no effect
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read-latency alignment; abort does not flush reads already issued
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid_pipe <= '0;
        end else begin
            r_valid_pipe[0] <= r_mem_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_valid_pipe[i] <= r_valid_pipe[i-1];
            end
        end
    end

    assign o_mem_addr    = r_mem_addr;
    assign o_mem_en      = r_mem_en;
    assign o_instr_valid = r_valid_pipe[RD_LATENCY-1];
    assign o_busy        = (r_state == S_DELAY) || (r_state == S_RUN);
    assign o_done        = r_done;
    assign o_aborted     = r_aborted;
    assign o_cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_dds_playback_sequencer.sv
// tb/tb_dds_playback_sequencer.sv - self-checking bench for dds_playback_sequencer
module tb_dds_playback_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [16:0] cfg_start_addr;
    logic [17:0] cfg_num_instr;
    logic [15:0] cfg_dwell;
    logic [31:0] cfg_delay;
    logic [7:0]  cfg_loops;
    logic [16:0] mem_addr;
    logic        mem_en;
    logic        instr_valid;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state carried between transactions
    logic [16:0] m_addr;

    always #5 clk = ~clk;

    dds_playback_sequencer #(
        .ADDR_W(17), .DWELL_W(16), .DELAY_W(32), .LOOP_W(8), .RD_LATENCY(1)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_start          (start),
        .i_abort          (abort),
        .i_cfg_start_addr (cfg_start_addr),
        .i_cfg_num_instr  (cfg_num_instr),
        .i_cfg_dwell      (cfg_dwell),
        .i_cfg_delay      (cfg_delay),
        .i_cfg_loops      (cfg_loops),
        .o_mem_addr       (mem_addr),
        .o_mem_en         (mem_en),
        .o_instr_valid    (instr_valid),
        .o_busy           (busy),
        .o_done           (done),
        .o_aborted        (aborted),
        .o_cfg_err        (cfg_err)
    );

    typedef struct {
        logic [16:0] sa;
        logic [17:0] n;
        logic [15:0] dw;
        logic [31:0] dl;
        logic [7:0]  lp;
        int          restart_at;
        int          exp_reads;
        int          exp_done;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Issue one start and check every following cycle against the timing rules:
    // read k (k = 0..L*N-1) occurs at offset 1+D+k*W with address sa+(k mod N),
    // done at offset D+L*N*W+1, instr_valid is mem_en one cycle later.
    task automatic run_case(input logic [16:0] sa, input logic [17:0] n, input logic [15:0] dw,
                            input logic [31:0] dl, input logic [7:0] lp, input int abort_at,
                            input int restart_at, input int ncyc,
                            output int reads, output int done_t, output bit err_seen);
        longint D, N, W, L, tend, r;
        bit bad, prev_en;
        logic e_en, e_busy, e_done, e_ab, e_err;
        logic [16:0] e_addr;
        logic [22:0] act, exp;
        bad = (n == 0) || (dw == 0);
        D = longint'(dl); N = longint'(n); W = longint'(dw); L = longint'(lp);
        tend = (L == 0) ? (64'd1 << 40) : D + L * N * W;
        reads = 0; done_t = 0; err_seen = 0;
        @(negedge clk);
        cfg_start_addr = sa; cfg_num_instr = n; cfg_dwell = dw;
        cfg_delay = dl; cfg_loops = lp; start = 1'b1;
        prev_en = 1'b0;
        for (int t = 1; t <= ncyc; t++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            e_en = 0; e_busy = 0; e_done = 0; e_ab = 0; e_err = 0; e_addr = m_addr;
            if (bad) begin
                e_err = (t == 1);
            end else if (abort_at > 0 && t > abort_at) begin
                e_ab = (t == abort_at + 1);
            end else begin
                e_busy = (t <= tend);
                if (t > D && t <= tend) begin
                    r = t - 1 - D;
                    if (r % W == 0) begin
                        e_en = 1;
                        e_addr = 17'(longint'(sa) + (r / W) % N);
                    end
                end
                e_done = (t == tend + 1);
            end
            exp = {e_addr, e_en, prev_en, e_busy, e_done, e_ab, e_err};
            act = {mem_addr, mem_en, instr_valid, busy, done, aborted, cfg_err};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL cycle t=%0d sa=%0d n=%0d dw=%0d dl=%0d lp=%0d act=%h exp=%h",
                         t, sa, n, dw, dl, lp, act, exp);
            end
            m_addr = e_addr;
            prev_en = e_en;
            if (mem_en) reads++;
            if (done) done_t = t;
            if (cfg_err) err_seen = 1;
            if (t == abort_at) abort = 1'b1;
            if (t == restart_at) begin
                start = 1'b1;
                cfg_start_addr = sa + 17'd50;
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    vec_t tbl[8];

    initial begin
        int reads, done_t;
        bit err_seen;
        logic [22:0] act;

        tbl[0] = '{sa:17'd100,    n:18'd4, dw:16'd3, dl:32'd0, lp:8'd1,   restart_at:0, exp_reads:4,   exp_done:13,  exp_err:0};
        tbl[1] = '{sa:17'd7,      n:18'd1, dw:16'd1, dl:32'd5, lp:8'd1,   restart_at:0, exp_reads:1,   exp_done:7,   exp_err:0};
        tbl[2] = '{sa:17'd131070, n:18'd4, dw:16'd1, dl:32'd0, lp:8'd3,   restart_at:0, exp_reads:12,  exp_done:13,  exp_err:0};
        tbl[3] = '{sa:17'd10,     n:18'd0, dw:16'd2, dl:32'd0, lp:8'd1,   restart_at:0, exp_reads:0,   exp_done:0,   exp_err:1};
        tbl[4] = '{sa:17'd10,     n:18'd3, dw:16'd0, dl:32'd3, lp:8'd1,   restart_at:0, exp_reads:0,   exp_done:0,   exp_err:1};
        tbl[5] = '{sa:17'd5,      n:18'd1, dw:16'd1, dl:32'd0, lp:8'd255, restart_at:0, exp_reads:255, exp_done:256, exp_err:0};
        tbl[6] = '{sa:17'd0,      n:18'd3, dw:16'd2, dl:32'd2, lp:8'd2,   restart_at:0, exp_reads:6,   exp_done:15,  exp_err:0};
        tbl[7] = '{sa:17'd100,    n:18'd4, dw:16'd3, dl:32'd0, lp:8'd1,   restart_at:5, exp_reads:4,   exp_done:13,  exp_err:0};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_start_addr = '0; cfg_num_instr = '0; cfg_dwell = '0; cfg_delay = '0; cfg_loops = '0;
        m_addr = '0;
        repeat (3) @(negedge clk);
        act = {mem_addr, mem_en, instr_valid, busy, done, aborted, cfg_err};
        check("reset_outputs", longint'(act), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_case(tbl[i].sa, tbl[i].n, tbl[i].dw, tbl[i].dl, tbl[i].lp, 0, tbl[i].restart_at,
                     tbl[i].exp_err ? 4 : tbl[i].exp_done + 3, reads, done_t, err_seen);
            check($sformatf("vec%0d_reads", i), reads, tbl[i].exp_reads);
            check($sformatf("vec%0d_done_t", i), done_t, tbl[i].exp_done);
            check($sformatf("vec%0d_cfg_err", i), err_seen, tbl[i].exp_err);
        end

        // Infinite looping, aborted mid-RUN: reads at t=1,3,5,7,9, no done
        run_case(17'd40, 18'd2, 16'd2, 32'd0, 8'd0, 9, 0, 14, reads, done_t, err_seen);
        check("inf_abort_reads", reads, 5);
        check("inf_abort_no_done", done_t, 0);

        // Abort during the delay
        run_case(17'd300, 18'd2, 16'd1, 32'd6, 8'd1, 3, 0, 8, reads, done_t, err_seen);
        check("delay_abort_reads", reads, 0);

        // Reset mid-RUN, then a fresh start replays from the start address
        run_case(17'd500, 18'd8, 16'd2, 32'd0, 8'd1, 0, 0, 6, reads, done_t, err_seen);
        reset = 1'b1;
        @(negedge clk);
        act = {mem_addr, mem_en, instr_valid, busy, done, aborted, cfg_err};
        check("reset_mid_run", longint'(act), 0);
        reset = 1'b0;
        m_addr = '0;
        run_case(17'd500, 18'd3, 16'd1, 32'd0, 8'd1, 0, 0, 6, reads, done_t, err_seen);
        check("replay_reads", reads, 3);
        check("replay_done_t", done_t, 4);

        // Randomized configurations against the arithmetic model
        for (int k = 0; k < 25; k++) begin
            logic [16:0] sa;
            logic [17:0] n;
            logic [15:0] dw;
            logic [31:0] dl;
            logic [7:0]  lp;
            int tend, ab, nc;
            sa = ($urandom_range(0, 1) == 1) ? 17'(131072 - $urandom_range(1, 4)) : 17'($urandom);
            n  = 18'($urandom_range(1, 5));
            dw = 16'($urandom_range(1, 4));
            dl = 32'($urandom_range(0, 6));
            lp = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) n = 18'd0;
            tend = int'(dl) + int'(lp) * int'(n) * int'(dw);
            ab = 0;
            if (n == 0) begin
                nc = 4;
            end else if (lp == 0) begin
                ab = $urandom_range(1, 30);
                nc = ab + 3;
            end else begin
                if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, tend);
                nc = (ab > 0) ? ab + 3 : tend + 3;
            end
            run_case(sa, n, dw, dl, lp, ab, 0, nc, reads, done_t, err_seen);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
